bshift_multistep: RTL and testbench

Iterative shift sequencer that sits around the 4-bit barrel shifter stage (`Bshifter4`, 2-bit amount, 0–3 positions). It accepts a 4-bit operand and a 4-bit total shift amount (0–15). It then drives the shifter once per cycle with chunks of at most 3, feeding each shifter output back as the next operand. The block presents the final value with a one-cycle `done` pulse. It is both the upstream feeder (drives A/N) and the downstream consumer (registers the output) of the shifter.

---
 rtl/bshift_pkg.sv | 8 +
 rtl/bshift_step_sel.sv | 17 +
 rtl/bshift_multistep.sv | 78 +++++++
 tb/tb_bshift_multistep.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bshift_pkg.sv
// Shared types and constants for the iterative shift sequencer.
package bshift_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} bshift_state_t;

  localparam int BSH_W        = 4;
  localparam int BSH_AMT_W    = 4;
  localparam int BSH_MAX_STEP = 3;
endpackage

// File: rtl/bshift_step_sel.sv
// Splits the remaining shift amount into one shifter-sized step plus what is left.
module bshift_step_sel
  import bshift_pkg::*;
#(
  parameter int AMT_W = BSH_AMT_W
) (
  input  logic [AMT_W-1:0] rem,
  output logic [1:0]       step,
  output logic [AMT_W-1:0] rem_next
);
  logic big;

  assign big      = rem > AMT_W'(BSH_MAX_STEP);
  assign step     = big ? 2'(BSH_MAX_STEP) : rem[1:0];
  // step never exceeds rem, so this subtraction cannot wrap
  assign rem_next = rem - {{(AMT_W-2){1'b0}}, step};
endmodule

// File: rtl/bshift_multistep.sv
// Drives an external 2-bit-amount shifter once per cycle, feeding its output back
// until the requested total shift is consumed, then pulses done with the result.
module bshift_multistep
  import bshift_pkg::*;
#(
  parameter int W     = BSH_W,
  parameter int AMT_W = BSH_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     data_in,
  input  logic [AMT_W-1:0] amount,
  output logic [W-1:0]     sh_a,
  output logic [1:0]       sh_n,
  input  logic [W-1:0]     sh_y,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result
);
  bshift_state_t    state, state_nxt;
  logic [W-1:0]     acc;
  logic [AMT_W-1:0] rem, rem_next;
  logic [1:0]       step;

  bshift_step_sel #(.AMT_W(AMT_W)) u_step_sel (
    .rem      (rem),
    .step     (step),
    .rem_next (rem_next)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    sh_n      = 2'b0;
    sh_a      = acc;
    case (state)
      IDLE: if (start) state_nxt = (amount == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        sh_n = step;
        if (rem_next == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          acc <= data_in;
          rem <= amount;
          // zero-length request bypasses the shifter entirely
          if (amount == '0) result <= data_in;
        end
        RUN: begin
          acc <= sh_y;
          rem <= rem_next;
          if (rem_next == '0) result <= sh_y;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bshift_multistep.sv
// Directed bench: sequencer wrapped with a behavioural logical-left-shift stage.
module tb_bshift_multistep;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] data_in, amount, sh_a, sh_y, result;
  logic [1:0] sh_n;
  logic       busy, done;

  int nvec = 0, nmis = 0;
  logic [3:0] la [8];
  logic [1:0] ln [8];
  int nst, lat, nbusy;

  always #5 clk = ~clk;

  assign sh_y = sh_a << sh_n;

  bshift_multistep dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .amount(amount),
    .sh_a(sh_a), .sh_n(sh_n), .sh_y(sh_y), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [3:0] exp_res);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".sh_n"}, sh_n, 2'd0);
    chk({tag, ".result"}, result, exp_res);
  endtask

  // Issue one request, log every RUN step, stop in the done cycle.
  task automatic go(input logic [3:0] d, input logic [3:0] a);
    data_in = d; amount = a; start = 1'b1;
    tick();
    start = 1'b0;
    nst = 0; lat = 1; nbusy = 0;
    while (!done && lat < 12) begin
      if (busy) nbusy++;
      if (nst < 8) begin la[nst] = sh_a; ln[nst] = sh_n; end
      nst++;
      tick();
      lat++;
    end
    if (!done) chk("done_timeout", 1'b0, 1'b1);
    if (busy) nbusy++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; amount = '0;
    tick(); tick();
    chk_idle("reset", 4'h0);
    chk("reset.sh_a", sh_a, 4'h0);
    rst = 1'b0;

    // amount 0: immediate DONE, shifter never driven
    go(4'b1010, 4'd0);
    chk("a0.lat", lat, 1);
    chk("a0.result", result, 4'b1010);
    chk("a0.sh_n", sh_n, 2'd0);
    tick();
    chk_idle("a0.after", 4'b1010);

    go(4'b0001, 4'd2);
    chk("a2.lat", lat, 2);
    chk("a2.step_a", la[0], 4'b0001);
    chk("a2.step_n", ln[0], 2'd2);
    chk("a2.result", result, 4'b0100);
    tick();

    go(4'b1101, 4'd5);
    chk("a5.lat", lat, 3);
    chk("a5.a0", la[0], 4'b1101);
    chk("a5.n0", ln[0], 2'd3);
    chk("a5.a1", la[1], 4'b1000);
    chk("a5.n1", ln[1], 2'd2);
    chk("a5.busy_cycles", nbusy, 3);
    chk("a5.result", result, 4'b0000);
    tick();

    go(4'b0001, 4'd15);
    chk("a15.lat", lat, 6);
    chk("a15.n4", ln[4], 2'd3);
    chk("a15.a1", la[1], 4'b1000);
    chk("a15.result", result, 4'b0000);
    tick();
    chk_idle("a15.after", 4'b0000);

    // second start pulsed during RUN must be dropped
    data_in = 4'b0001; amount = 4'd3; start = 1'b1;
    tick();
    chk("busy.run_n", sh_n, 2'd3);
    data_in = 4'b1111; amount = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy.done", done, 1'b1);
    chk("busy.result", result, 4'b1000);
    tick();
    chk_idle("busy.after", 4'b1000);

    // reset during the second step of a 3-step request
    data_in = 4'b0001; amount = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst.step2_a", sh_a, 4'b1000);
    chk("rst.step2_n", sh_n, 2'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst.state", 4'h0);
    chk("rst.sh_a", sh_a, 4'h0);
    tick();
    chk("rst.no_done", done, 1'b0);

    go(4'b0011, 4'd1);
    chk("post.lat", lat, 2);
    chk("post.result", result, 4'b0110);
    tick();

    // start held high: a new request accepted in the IDLE cycle after DONE
    data_in = 4'b0001; amount = 4'd1; start = 1'b1;
    tick();   // RUN
    tick();   // DONE
    chk("hold.done1", done, 1'b1);
    tick();   // IDLE, accepts again
    chk("hold.idle", busy, 1'b0);
    tick();   // RUN
    chk("hold.run", sh_n, 2'd1);
    start = 1'b0;
    tick();
    chk("hold.done2", done, 1'b1);
    chk("hold.result", result, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
